mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port, synchronous-read unified instruction/data memory between the instruction-fetch stage and the load/store stage. Sits between the pipeline front/back ends and the memory macro. Grants at most one access per cycle, tags each accepted access, and routes the memory's one-cycle-latency read data back to the originating requester. Counts contention cycles for performance tuning.

---
 rtl/mem_arbiter_pkg.sv | 6 +
 rtl/mem_arbiter_rr_arb2.sv | 38 +++
 rtl/mem_arbiter.sv | 83 ++++++++
 tb/tb_mem_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the unified-memory arbiter.
package mem_arbiter_pkg;
  localparam int   WORD_LEN = 32;
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. req[0] is fetch, req[1] is load/store.
// last_src remembers the most recent winner so contention alternates.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_src
);

  logic last_src_q, last_src_d;

  // Pick a winner; under contention the source not granted last wins.
  // Grants are forced off while reset is held.
  always_comb begin
    gnt        = 2'b00;
    gnt_src    = SRC_INST;
    last_src_d = last_src_q;
    if (!rst) begin
      if (req[0] && req[1]) gnt_src = ~last_src_q;
      else if (req[1])      gnt_src = SRC_DATA;
      else                  gnt_src = SRC_INST;
      if (|req) begin
        gnt        = (gnt_src == SRC_DATA) ? 2'b10 : 2'b01;
        last_src_d = gnt_src;
      end
    end
  end

  // Last-winner register; reset to INST so the first contest goes to DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_src_q <= SRC_INST;
    else     last_src_q <= last_src_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory port between fetch and load/store.
// Grants one access per cycle, tags it, and steers the next-cycle read
// data back as i_rvalid or d_rvalid. Counts contended cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [WORD_LEN-1:0] i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [WORD_LEN-1:0] i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [WORD_LEN-1:0] d_addr,
  input  logic [WORD_LEN-1:0] d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [WORD_LEN-1:0] d_rdata,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic                mem_wen,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic [WORD_LEN-1:0] mem_rdata,
  output logic [CNT_W-1:0]    conflict_cnt
);

  logic [1:0]       gnt;
  logic             gnt_src;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_src_q, resp_src_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({d_req, i_req}),
    .gnt     (gnt),
    .gnt_src (gnt_src)
  );

  assign i_gnt = gnt[0];
  assign d_gnt = gnt[1];

  // Memory port mux: data side only when it holds the grant; idle cycles
  // present the fetch address. Fetch can never write.
  always_comb begin
    mem_addr  = d_gnt ? d_addr : i_addr;
    mem_wdata = d_gnt ? d_wdata : '0;
    mem_wen   = d_gnt & d_we;
  end

  // Response tag and saturating contention counter next-state.
  always_comb begin
    resp_valid_d   = |gnt;
    resp_src_d     = gnt_src;
    conflict_cnt_d = conflict_cnt_q;
    if (i_req && d_req && (conflict_cnt_q != {CNT_W{1'b1}}))
      conflict_cnt_d = conflict_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Tag and counter registers; reset drops any outstanding response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q   <= 1'b0;
      resp_src_q     <= SRC_INST;
      conflict_cnt_q <= '0;
    end else begin
      resp_valid_q   <= resp_valid_d;
      resp_src_q     <= resp_src_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign i_rvalid     = resp_valid_q & (resp_src_q == SRC_INST);
  assign d_rvalid     = resp_valid_q & (resp_src_q == SRC_DATA);
  assign i_rdata      = mem_rdata;
  assign d_rdata      = mem_rdata;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a read-first synchronous memory model.
// A second instance with a 4-bit counter shares the stimulus for saturation.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_wen;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [15:0] cnt;

  logic        s_i_gnt, s_i_rvalid, s_d_gnt, s_d_rvalid, s_mem_wen;
  logic [31:0] s_i_rdata, s_d_rdata, s_mem_addr, s_mem_wdata;
  logic [3:0]  s_cnt;

  logic [31:0] mem [0:255];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(cnt)
  );

  mem_arbiter #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(s_i_gnt), .i_rvalid(s_i_rvalid), .i_rdata(s_i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(s_d_gnt), .d_rvalid(s_d_rvalid), .d_rdata(s_d_rdata),
    .mem_addr(s_mem_addr), .mem_wen(s_mem_wen), .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(s_cnt)
  );

  // Read-first single-port memory: old word is returned on a write.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[9:2]];
    if (mem_wen) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    drive_edge();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[4] = 32'h0050_0093;

    // Reset: requests high must not produce grants or writes.
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_cnt", cnt, 0);
    drive_edge();
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;

    // Lone fetch for 3 cycles.
    i_req = 1'b1; i_addr = 32'h10;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fetch_i_gnt", i_gnt, (k < 3) ? 1 : 0);
      if (k < 3) chk("fetch_addr", mem_addr, 32'h10);
      chk("fetch_i_rvalid", i_rvalid, (k > 0) ? 1 : 0);
      if (k > 0) chk("fetch_rdata", i_rdata, 32'h0050_0093);
      chk("fetch_d_rvalid", d_rvalid, 0);
      drive_edge();
      if (k == 2) i_req = 1'b0;
    end

    // Contention from reset: D, I, D, I.
    reset_dut();
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h10; d_addr = 32'h40; d_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_d_gnt", d_gnt, (k % 2 == 0) ? 1 : 0);
      chk("rr_i_gnt", i_gnt, (k % 2 == 1) ? 1 : 0);
      if (k > 0) chk("rr_d_rvalid", d_rvalid, ((k - 1) % 2 == 0) ? 1 : 0);
      drive_edge();
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("rr_cnt", cnt, 4);
    chk("rr_cnt4", s_cnt, 4);
    chk("rr_last_i_rvalid", i_rvalid, 1);
    drive_edge();

    // Store 0xDEADBEEF to 0x40, then load it back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("st_d_gnt", d_gnt, 1);
    chk("st_wen", mem_wen, 1);
    chk("st_addr", mem_addr, 32'h40);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    drive_edge();
    d_we = 1'b0;
    @(negedge clk);
    chk("ld_d_gnt", d_gnt, 1);
    chk("ld_wen", mem_wen, 0);
    chk("st_d_rvalid", d_rvalid, 1);
    drive_edge();
    d_req = 1'b0;
    @(negedge clk);
    chk("ld_d_rvalid", d_rvalid, 1);
    chk("ld_rdata", d_rdata, 32'hDEAD_BEEF);
    chk("ld_wen_after", mem_wen, 0);
    drive_edge();

    // Fetch with d_we high must not write.
    i_req = 1'b1; i_addr = 32'h40; d_we = 1'b1; d_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("fw_i_gnt", i_gnt, 1);
    chk("fw_wen", mem_wen, 0);
    drive_edge();
    i_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("fw_i_rvalid", i_rvalid, 1);
    chk("fw_rdata", i_rdata, 32'hDEAD_BEEF);
    drive_edge();

    // Reset mid-access: make DATA the last winner, then reset during a load grant.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    @(negedge clk);
    chk("ra_pre_gnt", d_gnt, 1);
    drive_edge();
    @(negedge clk);
    chk("ra_d_gnt", d_gnt, 1);
    #1;
    rst = 1'b1; d_we = 1'b1;
    #1;
    chk("ra_gnt_gated", d_gnt, 0);
    chk("ra_wen_gated", mem_wen, 0);
    @(posedge clk);
    @(negedge clk);
    chk("ra_d_rvalid", d_rvalid, 0);
    chk("ra_i_rvalid", i_rvalid, 0);
    chk("ra_cnt", cnt, 0);
    drive_edge();
    rst = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    @(negedge clk);
    chk("ra_last_d_gnt", d_gnt, 1);
    chk("ra_last_i_gnt", i_gnt, 0);
    drive_edge();

    // Saturation: 20 contended cycles, 4-bit counter holds at 15.
    reset_dut();
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("sat_cnt4", s_cnt, (k < 15) ? k : 15);
      chk("sat_cnt16", cnt, k);
    end
    i_req = 1'b0; d_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
